// File: rtl/rbf_pkg.sv
// Shared definitions for the sequential RBF layer: one-hot FSM states,
// coefficient-word field layout and activation-function type codes.
package rbf_pkg;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_FETCH = 7'b0000010,
    S_LOAD  = 7'b0000100,
    S_FIRE  = 7'b0001000,
    S_WAIT  = 7'b0010000,
    S_ACC   = 7'b0100000,
    S_DONE  = 7'b1000000
  } state_e;

  // Coefficient word is {func_type, w, s, b1, b, a1, a0}; each operand
  // field is N bits wide and field f starts at bit f*N.
  localparam int FLD_A0  = 0;
  localparam int FLD_A1  = 1;
  localparam int FLD_B   = 2;
  localparam int FLD_B1  = 3;
  localparam int FLD_S   = 4;
  localparam int FLD_W   = 5;
  localparam int FLD_FT  = 6;
  localparam int NUM_OPS = 6;
  localparam int FT_W    = 2;

  typedef enum logic [1:0] {
    FT_NORM0      = 2'd0,
    FT_NORM1      = 2'd1,
    FT_LEFT_HIGH  = 2'd2,
    FT_RIGHT_HIGH = 2'd3
  } func_type_e;

  function automatic int fld_lsb(input int fld, input int n);
    return fld * n;
  endfunction

endpackage

// File: rtl/rbf_sat_acc.sv
// Signed layer accumulator with N-bit saturation of the value it is about
// to hold, so the caller can register the clamped sum in the same cycle.
module rbf_sat_acc #(
  parameter int N  = 16,
  parameter int AW = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [N-1:0] din,
  output logic [N-1:0] sat_next
);

  localparam logic signed [AW-1:0] MAXV = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  function automatic logic [N-1:0] saturate(input logic signed [AW-1:0] v);
    if (v > MAXV) begin
      return {1'b0, {(N-1){1'b1}}};
    end else if (v < MINV) begin
      return {1'b1, {(N-1){1'b0}}};
    end else begin
      return v[N-1:0];
    end
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{(AW-N){din[N-1]}}, din};
    end
  end

  assign sat_next = saturate(acc_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rbf_layer_seq.sv
// Sequential RBF layer: walks K neurons, hands each coefficient set to an
// external activation function and sums the results with saturation.
module rbf_layer_seq
  import rbf_pkg::*;
#(
  parameter int N   = 16,
  parameter int K   = 8,
  parameter int KW  = 3,
  parameter int TMO = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N-1:0]               x,
  output logic [KW-1:0]              cm_addr,
  input  logic [NUM_OPS*N+FT_W-1:0]  cm_rdata,
  output logic [N-1:0]               af_x,
  output logic [N-1:0]               af_a0,
  output logic [N-1:0]               af_a1,
  output logic [N-1:0]               af_b,
  output logic [N-1:0]               af_b1,
  output logic [N-1:0]               af_s,
  output logic [N-1:0]               af_w,
  output logic [1:0]                 af_func_type,
  output logic                       af_start,
  input  logic [N-1:0]               af_y,
  input  logic                       af_rdy,
  output logic [N-1:0]               y,
  output logic                       rdy,
  output logic                       busy,
  output logic                       err
);

  localparam int AW = N + KW + 1;
  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] cm_addr_q, cm_addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [N-1:0]  afy_q, afy_d;
  logic [N-1:0]  y_q, y_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          af_start_q, af_start_d;
  logic [N-1:0]  af_x_q, af_x_d;
  logic [N-1:0]  af_a0_q, af_a0_d;
  logic [N-1:0]  af_a1_q, af_a1_d;
  logic [N-1:0]  af_b_q, af_b_d;
  logic [N-1:0]  af_b1_q, af_b1_d;
  logic [N-1:0]  af_s_q, af_s_d;
  logic [N-1:0]  af_w_q, af_w_d;
  func_type_e    af_ft_q, af_ft_d;

  logic          acc_clr;
  logic          acc_add;
  logic [N-1:0]  sat_next;

  rbf_sat_acc #(
    .N  (N),
    .AW (AW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .din      (afy_q),
    .sat_next (sat_next)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cm_addr_d  = cm_addr_q;
    tmo_d      = tmo_q;
    afy_d      = afy_q;
    y_d        = y_q;
    rdy_d      = 1'b0;
    err_d      = err_q;
    af_start_d = 1'b0;
    af_x_d     = af_x_q;
    af_a0_d    = af_a0_q;
    af_a1_d    = af_a1_q;
    af_b_d     = af_b_q;
    af_b1_d    = af_b1_q;
    af_s_d     = af_s_q;
    af_w_d     = af_w_q;
    af_ft_d    = af_ft_q;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          af_x_d    = x;
          k_d       = '0;
          cm_addr_d = '0;
          acc_clr   = 1'b1;
          err_d     = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Read data for the address presented in FETCH is valid now.
        af_a0_d    = cm_rdata[fld_lsb(FLD_A0, N) +: N];
        af_a1_d    = cm_rdata[fld_lsb(FLD_A1, N) +: N];
        af_b_d     = cm_rdata[fld_lsb(FLD_B, N) +: N];
        af_b1_d    = cm_rdata[fld_lsb(FLD_B1, N) +: N];
        af_s_d     = cm_rdata[fld_lsb(FLD_S, N) +: N];
        af_w_d     = cm_rdata[fld_lsb(FLD_W, N) +: N];
        af_ft_d    = func_type_e'(cm_rdata[fld_lsb(FLD_FT, N) +: FT_W]);
        af_start_d = 1'b1;
        state_d    = S_FIRE;
      end
      S_FIRE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (af_rdy) begin
          afy_d   = af_y;
          state_d = S_ACC;
        end else if (tmo_q == TW'(TMO)) begin
          err_d   = 1'b1;
          y_d     = '0;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ACC: begin
        acc_add = 1'b1;
        if (k_q == KW'(K - 1)) begin
          y_d     = sat_next;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d       = k_q + KW'(1);
          cm_addr_d = k_q + KW'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cm_addr_q  <= '0;
      tmo_q      <= '0;
      afy_q      <= '0;
      y_q        <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      af_start_q <= 1'b0;
      af_x_q     <= '0;
      af_a0_q    <= '0;
      af_a1_q    <= '0;
      af_b_q     <= '0;
      af_b1_q    <= '0;
      af_s_q     <= '0;
      af_w_q     <= '0;
      af_ft_q    <= FT_NORM0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cm_addr_q  <= cm_addr_d;
      tmo_q      <= tmo_d;
      afy_q      <= afy_d;
      y_q        <= y_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      af_start_q <= af_start_d;
      af_x_q     <= af_x_d;
      af_a0_q    <= af_a0_d;
      af_a1_q    <= af_a1_d;
      af_b_q     <= af_b_d;
      af_b1_q    <= af_b1_d;
      af_s_q     <= af_s_d;
      af_w_q     <= af_w_d;
      af_ft_q    <= af_ft_d;
    end
  end

  assign cm_addr      = cm_addr_q;
  assign af_x         = af_x_q;
  assign af_a0        = af_a0_q;
  assign af_a1        = af_a1_q;
  assign af_b         = af_b_q;
  assign af_b1        = af_b1_q;
  assign af_s         = af_s_q;
  assign af_w         = af_w_q;
  assign af_func_type = af_ft_q;
  assign af_start     = af_start_q;
  assign y            = y_q;
  assign rdy          = rdy_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_rbf_layer_seq.sv
// Scoreboard bench for rbf_layer_seq with a behavioural coefficient memory
// and activation-function model; expected sums come from plain arithmetic.
module tb_rbf_layer_seq;

  localparam int N   = 16;
  localparam int K   = 4;
  localparam int KW  = 2;
  localparam int TMO = 60;
  localparam int CW  = 6 * N + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  x;
  logic [KW-1:0] cm_addr;
  logic [CW-1:0] cm_rdata;
  logic [N-1:0]  af_x, af_a0, af_a1, af_b, af_b1, af_s, af_w;
  logic [1:0]    af_func_type;
  logic          af_start;
  logic [N-1:0]  af_y;
  logic          af_rdy;
  logic [N-1:0]  y;
  logic          rdy;
  logic          busy;
  logic          err;

  rbf_layer_seq #(.N(N), .K(K), .KW(KW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .cm_addr(cm_addr), .cm_rdata(cm_rdata),
    .af_x(af_x), .af_a0(af_a0), .af_a1(af_a1), .af_b(af_b), .af_b1(af_b1),
    .af_s(af_s), .af_w(af_w), .af_func_type(af_func_type),
    .af_start(af_start), .af_y(af_y), .af_rdy(af_rdy),
    .y(y), .rdy(rdy), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] y;
    bit           err;
    int           t0;
    int           lat;
  } exp_t;

  typedef struct {
    int           idx;
    logic [N-1:0] x;
  } op_t;

  exp_t          sb_q[$];
  op_t           op_q[$];
  logic [CW-1:0] mem [K];
  logic [N-1:0]  ay [K];
  int            af_lat   = 3;
  int            fail_idx = -1;
  bit            spur     = 1'b0;
  int            af_n     = 0;
  int            cyc      = 0;
  int            n_chk    = 0;
  int            n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficient memory with one cycle of read latency.
  initial begin : cmem
    int a;
    cm_rdata = '0;
    forever begin
      @(negedge clk);
      a = int'(cm_addr);
      @(posedge clk);
      #1 cm_rdata = mem[a];
    end
  end

  // Activation function: answers L cycles after af_start, optionally never
  // for one neuron, optionally with a stray af_rdy two cycles later.
  initial begin : af_model
    af_rdy = 1'b0;
    af_y   = '0;
    forever begin
      @(negedge clk);
      if (af_start && !rst) begin : fire
        int n;
        n = af_n;
        af_n++;
        if (n != fail_idx) begin
          repeat (af_lat) @(posedge clk);
          #1;
          af_rdy = 1'b1;
          af_y   = (n < K) ? ay[n] : '0;
          @(posedge clk);
          #1;
          af_rdy = 1'b0;
          af_y   = 16'h5A5A;
          if (spur) begin
            @(posedge clk);
            #1;
            af_rdy = 1'b1;
            af_y   = 16'h7FFF;
            @(posedge clk);
            #1;
            af_rdy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expected results on rdy and expected operands on af_start.
  initial begin : monitor
    exp_t          e;
    op_t           o;
    logic [CW-1:0] w;
    forever begin
      @(negedge clk);
      if (rdy) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rdy", 32'(rdy), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("y", 32'(y), 32'(e.y));
          check("err_at_rdy", 32'(err), 32'(e.err));
          check("busy_at_rdy", 32'(busy), 32'd1);
          if (e.lat > 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
      if (af_start) begin
        if (op_q.size() == 0) begin
          check("unexpected_af_start", 32'(af_start), 32'd0);
        end else begin
          o = op_q.pop_front();
          w = mem[o.idx];
          check("cm_addr_seq", 32'(cm_addr), 32'(o.idx));
          check("af_x", 32'(af_x), 32'(o.x));
          check("af_a0", 32'(af_a0), 32'(w[0*N +: N]));
          check("af_a1", 32'(af_a1), 32'(w[1*N +: N]));
          check("af_b", 32'(af_b), 32'(w[2*N +: N]));
          check("af_b1", 32'(af_b1), 32'(w[3*N +: N]));
          check("af_s", 32'(af_s), 32'(w[4*N +: N]));
          check("af_w", 32'(af_w), 32'(w[5*N +: N]));
          check("af_func_type", 32'(af_func_type), 32'(w[6*N +: 2]));
        end
      end
    end
  end

  function automatic logic [N-1:0] clamp(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic zero_checks(input string tag);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_rdy"}, 32'(rdy), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_af_start"}, 32'(af_start), 32'd0);
    check({tag, "_cm_addr"}, 32'(cm_addr), 32'd0);
    check({tag, "_af_ops"}, 32'(af_x | af_a0 | af_a1 | af_b | af_b1 | af_s | af_w), 32'd0);
    check({tag, "_af_func_type"}, 32'(af_func_type), 32'd0);
  endtask

  // One evaluation: fidx >= 0 makes that neuron time out; extra pulses start
  // during WAIT; at_rdy holds start high in the rdy cycle.
  task automatic run(input logic [N-1:0] xv, input int lat, input int fidx,
                     input bit sp, input bit extra, input bit at_rdy);
    exp_t e;
    int   sum;
    int   nops;
    int   i;
    af_lat   = lat;
    fail_idx = fidx;
    spur     = sp;
    af_n     = 0;
    sum      = 0;
    for (int j = 0; j < K; j++) sum += int'($signed(ay[j]));
    if (fidx >= 0) begin
      e.y = '0; e.err = 1'b1; e.lat = -1; nops = fidx + 1;
    end else begin
      e.y = clamp(sum); e.err = 1'b0; e.lat = K * (4 + lat) + 1; nops = K;
    end
    for (int j = 0; j < nops; j++) op_q.push_back('{j, xv});
    start = 1'b1;
    x     = xv;
    e.t0  = cyc;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    x     = 16'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
    check("cm_addr_first_fetch", 32'(cm_addr), 32'd0);
    if (extra) begin
      repeat (3) tick();
      start = 1'b1;
      x     = ~xv;
      tick();
      start = 1'b0;
    end
    i = 0;
    while (!rdy && i < K * (4 + lat) + TMO + 40) begin
      tick();
      i++;
    end
    if (!rdy) begin
      check("rdy_wait_expired", 32'(rdy), 32'd1);
      sb_q.delete();
      op_q.delete();
    end else begin
      if (at_rdy) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      check("busy_after_done", 32'(busy), 32'd0);
      check("err_sticky", 32'(err), 32'(e.err));
      check("rdy_single_pulse", 32'(rdy), 32'd0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
    end
    repeat (6) tick();
  endtask

  initial begin : stim
    logic [CW-1:0] wd;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    for (int i = 0; i < K; i++) begin
      for (int f = 0; f < 6; f++) wd[f*N +: N] = {4'(i), 4'(f), 8'($urandom)};
      wd[6*N +: 2] = 2'(i);
      mem[i] = wd;
    end
    repeat (2) @(posedge clk);
    #2;
    zero_checks("reset");
    rst = 1'b0;
    repeat (2) tick();

    for (int j = 0; j < K; j++) ay[j] = 16'h1000;
    run(16'($urandom), 20, -1, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < K; j++) ay[j] = 16'h7000;
    run(16'($urandom), 2, -1, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < K; j++) ay[j] = 16'h9000;
    run(16'($urandom), 3, -1, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < K; j++) ay[j] = 16'($urandom_range(0, 16'h0FFF));
    run(16'($urandom), 2, 2, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < K; j++) ay[j] = 16'($urandom_range(0, 16'h0FFF));
    run(16'($urandom), 4, -1, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < K; j++) ay[j] = 16'($urandom) >> 2;
    run(16'($urandom), 5, -1, 1'b1, 1'b1, 1'b0);

    // Abort during neuron 3's fetch: only neurons 0..2 reach FIRE.
    for (int j = 0; j < K; j++) ay[j] = 16'h0800;
    af_lat = 3; fail_idx = -1; spur = 1'b0; af_n = 0;
    for (int j = 0; j < 3; j++) op_q.push_back('{j, 16'h1234});
    start = 1'b1;
    x     = 16'h1234;
    tick();
    start = 1'b0;
    repeat (21) tick();
    rst = 1'b1;
    #1;
    zero_checks("mid_rst");
    tick();
    rst = 1'b0;
    check("ops_before_abort", 32'(op_q.size()), 32'd0);
    op_q.delete();
    repeat (10) tick();
    check("idle_after_abort", 32'(busy), 32'd0);

    for (int j = 0; j < K; j++) ay[j] = 16'($urandom);
    run(16'h2000, 2, -1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < K; j++) ay[j] = 16'($urandom);
      run(16'($urandom), int'($urandom_range(1, 6)), -1, 1'(r % 2), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
